// File: rtl/operand_loader_if.sv
// Operand loader bus interface.
// Groups the load handshake, status and read-port signals of operand_loader.
//   start_i                 : single-cycle pulse that begins a load pass
//   in_valid_i / in_ready_o : operand-pair handshake
//   in_op1_i / in_op2_i     : operand write data
//   operand1_addr_i / operand2_addr_i : independent read addresses
//   operand1_o / operand2_o : combinational read data
//   busy_o / done_o         : LOAD / DONE status
//   load_count_o            : pairs accepted this pass (only with OPERAND_LOADER_CNT_EN)
// Modports: master drives the block (testbench/upstream), slave is the block.
interface operand_loader_if #(
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned MEM_WIDTH = 32
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic                 start_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [MEM_WIDTH-1:0] in_op1_i;
  logic [MEM_WIDTH-1:0] in_op2_i;
  logic [AW-1:0]        operand1_addr_i;
  logic [AW-1:0]        operand2_addr_i;
  logic [MEM_WIDTH-1:0] operand1_o;
  logic [MEM_WIDTH-1:0] operand2_o;
  logic                 busy_o;
  logic                 done_o;
`ifdef OPERAND_LOADER_CNT_EN
  logic [AW:0]          load_count_o;

  modport master (
    output start_i, in_valid_i, in_op1_i, in_op2_i, operand1_addr_i, operand2_addr_i,
    input  in_ready_o, operand1_o, operand2_o, busy_o, done_o, load_count_o
  );
  modport slave (
    input  start_i, in_valid_i, in_op1_i, in_op2_i, operand1_addr_i, operand2_addr_i,
    output in_ready_o, operand1_o, operand2_o, busy_o, done_o, load_count_o
  );
`else
  modport master (
    output start_i, in_valid_i, in_op1_i, in_op2_i, operand1_addr_i, operand2_addr_i,
    input  in_ready_o, operand1_o, operand2_o, busy_o, done_o
  );
  modport slave (
    input  start_i, in_valid_i, in_op1_i, in_op2_i, operand1_addr_i, operand2_addr_i,
    output in_ready_o, operand1_o, operand2_o, busy_o, done_o
  );
`endif
endinterface

// File: rtl/operand_loader.sv
// Operand loader: fills two MEM_DEPTH x MEM_WIDTH operand arrays from a
// valid/ready stream of operand pairs, then holds them for a downstream stage
// that reads both arrays combinationally at independent addresses.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (clears FSM, pointer and arrays)
//   bus    : operand_loader_if.slave (handshake, read ports, status)
// Optional feature: define OPERAND_LOADER_CNT_EN to add bus.load_count_o,
// the number of pairs accepted in the current pass (saturates at MEM_DEPTH).
module operand_loader #(
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned MEM_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  operand_loader_if.slave   bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state;
  logic [AW-1:0]        wr_ptr;
  logic [MEM_WIDTH-1:0] mem1 [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] mem2 [MEM_DEPTH];
  logic                 fire;

  assign fire = bus.in_valid_i && (state == ST_LOAD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start_i) begin
            state  <= ST_LOAD;
            wr_ptr <= '0;
          end
        end
        ST_LOAD: begin
          if (fire) begin
            // Power-of-two depth: the increment wraps to 0 on the last entry.
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == AW'(MEM_DEPTH - 1)) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
      end
    end else if (fire) begin
      mem1[wr_ptr] <= bus.in_op1_i;
      mem2[wr_ptr] <= bus.in_op2_i;
    end
  end

  // Reads see the array before the current edge's write.
  assign bus.operand1_o = mem1[bus.operand1_addr_i];
  assign bus.operand2_o = mem2[bus.operand2_addr_i];
  assign bus.in_ready_o = (state == ST_LOAD);
  assign bus.busy_o     = (state == ST_LOAD);
  assign bus.done_o     = (state == ST_DONE);

`ifdef OPERAND_LOADER_CNT_EN
  logic [AW:0] load_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_count <= '0;
    end else if ((state != ST_LOAD) && bus.start_i) begin
      load_count <= '0;
    end else if (fire && (load_count != (AW+1)'(MEM_DEPTH))) begin
      load_count <= load_count + 1'b1;
    end
  end

  assign bus.load_count_o = load_count;
`endif
endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: randomized operand pairs checked
// against a queue-free array model of the load passes.
module tb_operand_loader;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  operand_loader_if #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(WIDTH)) bus ();

  operand_loader #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(WIDTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents plus pass progress.
  logic [WIDTH-1:0] m1 [DEPTH];
  logic [WIDTH-1:0] m2 [DEPTH];
  bit m_loading;
  bit m_done;
  int m_ptr;
  int m_count;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m1[i] = '0;
      m2[i] = '0;
    end
    m_loading = 0; m_done = 0; m_ptr = 0; m_count = 0;
  endfunction

  function automatic void model_update(bit s, bit v, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    if (m_loading) begin
      if (v) begin
        m1[m_ptr] = a;
        m2[m_ptr] = b;
        m_ptr++;
        m_count++;
        if (m_ptr == DEPTH) begin
          m_ptr = 0; m_loading = 0; m_done = 1;
        end
      end
    end else if (s) begin
      m_loading = 1; m_done = 0; m_ptr = 0; m_count = 0;
    end
  endfunction

  // One clock: present inputs, let the edge happen, advance the model.
  task automatic tick(input bit s, input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start_i = s; bus.in_valid_i = v; bus.in_op1_i = a; bus.in_op2_i = b;
    @(posedge clk_i);
    model_update(s, v, a, b);
    #1;
    bus.start_i = 1'b0; bus.in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 0; bus.in_valid_i = 0; bus.in_op1_i = '0; bus.in_op2_i = '0;
    bus.operand1_addr_i = '0; bus.operand2_addr_i = '0;
    rst_ni = 1'b0;
    model_reset();
    #12;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done_o); end
    checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", bus.in_ready_o); end
    for (int i = 0; i < DEPTH; i++) begin
      bus.operand1_addr_i = 3'(i); bus.operand2_addr_i = 3'(DEPTH - 1 - i); #1;
      checks++; if (bus.operand1_o !== '0 || bus.operand2_o !== '0) begin
        errors++; $display("FAIL reset_read[%0d] got %h/%h expected 0/0", i, bus.operand1_o, bus.operand2_o);
      end
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_load();
    tick(1, 0, '0, '0);
    checks++; if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL load_enter got busy=%b ready=%b expected 1/1", bus.busy_o, bus.in_ready_o);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) begin
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL load_early_done got %b expected 0", bus.done_o); end
      end
      tick(0, 1, WIDTH'(k), WIDTH'(10 + k));
    end
    checks++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL load_done got done=%b busy=%b ready=%b expected 1/0/0", bus.done_o, bus.busy_o, bus.in_ready_o);
    end
    for (int k = 0; k < DEPTH; k++) begin
      bus.operand1_addr_i = 3'(k); bus.operand2_addr_i = 3'(k); #1;
      checks++; if (bus.operand1_o !== WIDTH'(k) || bus.operand2_o !== WIDTH'(10 + k)) begin
        errors++; $display("FAIL load_read[%0d] got %0d/%0d expected %0d/%0d", k, bus.operand1_o, bus.operand2_o, k, 10 + k);
      end
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] a, b;
    tick(1, 0, '0, '0);
    for (int k = 0; k < 4; k++) tick(0, 1, $urandom, $urandom);
    for (int c = 0; c < 3; c++) begin
      // start_i is pulsed during one stall cycle and must be ignored in LOAD.
      tick(c == 1, 0, $urandom, $urandom);
      checks++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
        errors++; $display("FAIL stall[%0d] got busy=%b done=%b ready=%b expected 1/0/1", c, bus.busy_o, bus.done_o, bus.in_ready_o);
      end
    end
    a = $urandom; b = $urandom;
    tick(0, 1, a, b);
    bus.operand1_addr_i = 3'd4; bus.operand2_addr_i = 3'd4; #1;
    checks++; if (bus.operand1_o !== a || bus.operand2_o !== b) begin
      errors++; $display("FAIL stall_entry4 got %h/%h expected %h/%h", bus.operand1_o, bus.operand2_o, a, b);
    end
    bus.operand1_addr_i = 3'd5; #1;
    checks++; if (bus.operand1_o !== m1[5]) begin
      errors++; $display("FAIL stall_entry5 got %h expected %h", bus.operand1_o, m1[5]);
    end
    for (int k = 0; k < 3; k++) tick(0, 1, $urandom, $urandom);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL stall_done got %b expected 1", bus.done_o); end
  endtask

  task automatic test_done_ignore();
    bus.start_i = 0; bus.in_valid_i = 1; bus.in_op1_i = 32'hDEAD; bus.in_op2_i = 32'hBEEF; #1;
    checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL done_ready got %b expected 0", bus.in_ready_o); end
    tick(0, 1, 32'hDEAD, 32'hBEEF);
    tick(0, 1, 32'hDEAD, 32'hBEEF);
    for (int k = 0; k < DEPTH; k++) begin
      bus.operand1_addr_i = 3'(k); bus.operand2_addr_i = 3'(k); #1;
      checks++; if (bus.operand1_o !== m1[k] || bus.operand2_o !== m2[k]) begin
        errors++; $display("FAIL done_keep[%0d] got %h/%h expected %h/%h", k, bus.operand1_o, bus.operand2_o, m1[k], m2[k]);
      end
    end
    tick(1, 0, '0, '0);
    for (int k = 0; k < DEPTH; k++) tick(0, 1, $urandom, $urandom);
    for (int k = 0; k < DEPTH; k++) begin
      bus.operand1_addr_i = 3'(k); bus.operand2_addr_i = 3'(DEPTH - 1 - k); #1;
      checks++; if (bus.operand1_o !== m1[k] || bus.operand2_o !== m2[DEPTH - 1 - k]) begin
        errors++; $display("FAIL reload[%0d] got %h/%h expected %h/%h", k, bus.operand1_o, bus.operand2_o, m1[k], m2[DEPTH - 1 - k]);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [WIDTH-1:0] old1, b;
    tick(1, 0, '0, '0);
    tick(0, 1, $urandom, $urandom);
    tick(0, 1, $urandom, $urandom);
    old1 = m1[2];
    b = $urandom;
    bus.operand1_addr_i = 3'd2; bus.operand2_addr_i = 3'd2;
    bus.start_i = 0; bus.in_valid_i = 1; bus.in_op1_i = 32'd5; bus.in_op2_i = b; #1;
    checks++; if (bus.operand1_o !== old1) begin errors++; $display("FAIL rdw_old got %h expected %h", bus.operand1_o, old1); end
    @(posedge clk_i);
    model_update(0, 1, 32'd5, b);
    #1; bus.in_valid_i = 0;
    checks++; if (bus.operand1_o !== 32'd5 || bus.operand2_o !== b) begin
      errors++; $display("FAIL rdw_new got %h/%h expected 5/%h", bus.operand1_o, bus.operand2_o, b);
    end
    for (int k = 0; k < 5; k++) tick(0, 1, $urandom, $urandom);
  endtask

  task automatic test_random_reads();
    for (int n = 0; n < 12; n++) begin
      bus.operand1_addr_i = 3'($urandom_range(DEPTH - 1));
      bus.operand2_addr_i = (n % 3 == 0) ? bus.operand1_addr_i : 3'($urandom_range(DEPTH - 1));
      #1;
      checks++; if (bus.operand1_o !== m1[bus.operand1_addr_i] || bus.operand2_o !== m2[bus.operand2_addr_i]) begin
        errors++; $display("FAIL rand_read[%0d] got %h/%h expected %h/%h", n, bus.operand1_o, bus.operand2_o,
                           m1[bus.operand1_addr_i], m2[bus.operand2_addr_i]);
      end
    end
  endtask

  task automatic test_reset_midload();
    tick(1, 0, '0, '0);
    for (int k = 0; k < 3; k++) tick(0, 1, $urandom | 32'h1, $urandom | 32'h1);
    #2; rst_ni = 1'b0; model_reset(); #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++; $display("FAIL midreset_status got busy=%b ready=%b done=%b expected 0/0/0", bus.busy_o, bus.in_ready_o, bus.done_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(0, 1, $urandom, $urandom);
      checks++; if (bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        errors++; $display("FAIL midreset_nostart[%0d] got ready=%b busy=%b expected 0/0", c, bus.in_ready_o, bus.busy_o);
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      bus.operand1_addr_i = 3'(k); bus.operand2_addr_i = 3'(k); #1;
      checks++; if (bus.operand1_o !== m1[k] || bus.operand2_o !== '0) begin
        errors++; $display("FAIL midreset_read[%0d] got %h/%h expected 0/0", k, bus.operand1_o, bus.operand2_o);
      end
    end
  endtask

`ifdef OPERAND_LOADER_CNT_EN
  task automatic test_count();
    tick(1, 0, '0, '0);
    checks++; if (bus.load_count_o !== 4'(m_count)) begin errors++; $display("FAIL cnt_start got %0d expected %0d", bus.load_count_o, m_count); end
    for (int k = 0; k < 5; k++) tick(0, 1, $urandom, $urandom);
    checks++; if (bus.load_count_o !== 4'd5) begin errors++; $display("FAIL cnt_5 got %0d expected 5", bus.load_count_o); end
    for (int k = 0; k < 3; k++) tick(0, 1, $urandom, $urandom);
    tick(0, 1, $urandom, $urandom);
    checks++; if (bus.load_count_o !== 4'd8) begin errors++; $display("FAIL cnt_8 got %0d expected 8", bus.load_count_o); end
    tick(1, 0, '0, '0);
    checks++; if (bus.load_count_o !== 4'd0) begin errors++; $display("FAIL cnt_restart got %0d expected 0", bus.load_count_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_done_ignore();
    test_read_during_write();
    test_random_reads();
    test_reset_midload();
`ifdef OPERAND_LOADER_CNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
